// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter sharing one tristate bus between CHANNELS sources, with bounded tenure
// and hi-Z turnaround. Define TRISTATE_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module tristate_bus_arbiter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned MAX_HOLD   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS-1:0]       last,
  input  logic [CHANNELS*WIDTH-1:0] din,
  inout  wire  [WIDTH-1:0]          bus,
  output logic [CHANNELS-1:0]       grant,
  output logic [2:0]                owner,
  output logic                      bus_valid,
  output logic                      busy
);

  typedef enum logic [1:0] {StIdle, StDrive, StTurn} state_e;

  state_e              state_q, state_d;
  logic [CHANNELS-1:0] grant_q, grant_d;
  logic [2:0]          owner_q, owner_d;
  logic                bus_valid_q, bus_valid_d;
  logic                busy_q, busy_d;
  logic [3:0]          hold_q, hold_d;
  logic [2:0]          turn_q, turn_d;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
  logic [2:0]          ptr_q, ptr_d;
  logic [CHANNELS-1:0] req_rot;
  logic [3:0]          rr_sum;
`endif

  logic                sel_found;
  logic [2:0]          sel_idx;
  logic                owner_req, owner_last;
  logic [WIDTH-1:0]    drive_data;

  // Owner-side view of the per-channel inputs.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    drive_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (owner_q == 3'(i)) begin
        owner_req  = req[i];
        owner_last = last[i];
        drive_data = din[i*WIDTH +: WIDTH];
      end
    end
  end

  // Winner selection for the next IDLE edge.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef TRISTATE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < CHANNELS; i++) begin
      if (!sel_found && req[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
`else
    // Rotate so bit 0 is the pointer channel, then take the first set bit.
    req_rot = CHANNELS'({req, req} >> ptr_q);
    rr_sum  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!sel_found && req_rot[i]) begin
        sel_found = 1'b1;
        rr_sum    = {1'b0, ptr_q} + 4'(i);
        if (rr_sum >= 4'(CHANNELS)) begin
          rr_sum = rr_sum - 4'(CHANNELS);
        end
        sel_idx   = rr_sum[2:0];
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          state_d = StDrive;
          owner_d = sel_idx;
          hold_d  = 4'd1;
          for (int i = 0; i < CHANNELS; i++) begin
            grant_d[i] = (sel_idx == 3'(i));
          end
        end
      end
      StDrive: begin
        if (!owner_req || owner_last || (hold_q == 4'(MAX_HOLD))) begin
          state_d = StTurn;
          grant_d = '0;
          turn_d  = 3'd1;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
          ptr_d   = (owner_q == 3'(CHANNELS - 1)) ? 3'd0 : owner_q + 3'd1;
`endif
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      StTurn: begin
        if (turn_q == 3'(TURNAROUND)) begin
          state_d = StIdle;
        end else begin
          turn_d = turn_q + 3'd1;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
    bus_valid_d = (state_d == StDrive);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      owner_q     <= '0;
      bus_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      hold_q      <= '0;
      turn_q      <= '0;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      bus_valid_q <= bus_valid_d;
      busy_q      <= busy_d;
      hold_q      <= hold_d;
      turn_q      <= turn_d;
`ifndef TRISTATE_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // bus_valid_q clears asynchronously, so reset releases the bus without a clock.
  assign bus       = bus_valid_q ? drive_data : 'z;
  assign grant     = grant_q;
  assign owner     = owner_q;
  assign bus_valid = bus_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: stimulus queues expected bus beats, a negedge
// monitor pops and compares them. Honours TRISTATE_ARB_FIXED_PRIO_EN when defined.
module tb_tristate_bus_arbiter;

  typedef struct packed {
    logic [3:0] grant;
    logic [2:0] owner;
    logic [7:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] din;
  wire  [7:0]  bus;
  logic [3:0]  grant;
  logic [2:0]  owner;
  logic        bus_valid;
  logic        busy;
  wire         bus_z = (bus === 8'hzz);

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t mon_b;

  logic [7:0] ch_data [4] = '{8'h3C, 8'hFF, 8'hA5, 8'h5A};

  tristate_bus_arbiter #(
    .WIDTH(8), .CHANNELS(4), .TURNAROUND(1), .MAX_HOLD(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din), .bus(bus),
    .grant(grant), .owner(owner), .bus_valid(bus_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_z(input string name);
    checks++;
    if (!bus_z) begin
      errors++;
      $display("FAIL %s: bus=%h, expected zz", name, bus);
    end
  endtask

  task automatic expect_beat(input int ch);
    beat_t b;
    b.grant = 4'(1 << ch);
    b.owner = 3'(ch);
    b.data  = ch_data[ch];
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every driven beat must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("inv_valid_vs_grant", {31'b0, bus_valid}, {31'b0, grant != 4'b0});
        if (bus_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: grant=%b owner=%0d bus=%h, expected no beat",
                     grant, owner, bus);
          end else begin
            mon_b = exp_q.pop_front();
            check("beat_grant", {28'b0, grant}, {28'b0, mon_b.grant});
            check("beat_owner", {29'b0, owner}, {29'b0, mon_b.owner});
            check("beat_data", {24'b0, bus}, {24'b0, mon_b.data});
          end
        end else begin
          check_z("idle_bus_z");
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    last  = 4'b0000;
    for (int i = 0; i < 4; i++) din[i*8 +: 8] = ch_data[i];

    // Reset state with all requests asserted.
    tick(); tick();
    check_z("reset_bus_z");
    check("reset_grant", {28'b0, grant}, 32'd0);
    check("reset_valid", {31'b0, bus_valid}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_owner", {29'b0, owner}, 32'd0);

    // Single-cycle latency from request to driven bus.
    expect_beat(2);
    req   = 4'b0100;
    rst_n = 1'b1;
    tick();
    check("first_grant", {28'b0, grant}, 32'b0100);
    check("first_bus", {24'b0, bus}, 32'hA5);
    req = 4'b0000;
    tick();
    check_z("release_turn_z");
    check("release_turn_busy", {31'b0, busy}, 32'd1);
    tick();
    check("release_idle_busy", {31'b0, busy}, 32'd0);
    check("owner_kept", {29'b0, owner}, 32'd2);
    check("drained_p1", exp_q.size(), 32'd0);

    // Tenure cap: four beats, turnaround, idle, then re-grant.
    for (int i = 0; i < 5; i++) expect_beat(0);
    req = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("cap_bus", {24'b0, bus}, 32'h3C);
    end
    tick();
    check_z("cap_turn_z");
    check("cap_turn_busy", {31'b0, busy}, 32'd1);
    tick();
    check_z("cap_idle_z");
    check("cap_idle_busy", {31'b0, busy}, 32'd0);
    tick();
    check("cap_regrant", {28'b0, grant}, 32'b0001);
    req = 4'b0000;
    tick(); tick();
    check("drained_p2", exp_q.size(), 32'd0);

    // Early release after two beats; pointer wraps to channel 0.
    expect_beat(3);
    expect_beat(3);
    req = 4'b1000;
    tick();
    check("early_bus1", {24'b0, bus}, 32'h5A);
    tick();
    check("early_bus2", {24'b0, bus}, 32'h5A);
    req = 4'b0000;
    tick();
    check_z("early_z");
    tick();
    check("drained_p4", exp_q.size(), 32'd0);

    // Round-robin with one-beat tenures.
    for (int k = 0; k < 5; k++) expect_beat(k % 4);
    req  = 4'b1111;
    last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_grant", {28'b0, grant}, 32'(1 << (k % 4)));
      if (k == 4) begin
        req  = 4'b0000;
        last = 4'b0000;
      end
      tick();
      check_z("rr_turn_z");
      tick();
      check_z("rr_idle_z");
      check("rr_idle_busy", {31'b0, busy}, 32'd0);
    end
    check("drained_p3", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a tenure.
    expect_beat(1);
    req = 4'b0010;
    tick();
    check("mid_bus", {24'b0, bus}, 32'hFF);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_z("async_reset_z");
    check("async_reset_grant", {28'b0, grant}, 32'd0);
    check("async_reset_valid", {31'b0, bus_valid}, 32'd0);
    check("async_reset_owner", {29'b0, owner}, 32'd0);
    req = 4'b0000;
    #1 rst_n = 1'b1;
    tick();
    check("post_reset_busy", {31'b0, busy}, 32'd0);
    check("drained_p5", exp_q.size(), 32'd0);

    // Two competing requesters: fixed priority keeps ch1, round-robin alternates.
`ifdef TRISTATE_ARB_FIXED_PRIO_EN
    expect_beat(1); expect_beat(1); expect_beat(1);
`else
    expect_beat(1); expect_beat(3); expect_beat(1);
`endif
    req  = 4'b1010;
    last = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      tick();
`ifdef TRISTATE_ARB_FIXED_PRIO_EN
      check("prio_grant", {28'b0, grant}, 32'b0010);
`else
      check("prio_grant", {28'b0, grant}, (k == 1) ? 32'b1000 : 32'b0010);
`endif
      if (k == 2) begin
        req  = 4'b0000;
        last = 4'b0000;
      end
      tick(); tick();
    end
    check("drained_p6", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
